// File: rtl/mips_board_pkg.sv
// Shared board-level definitions for the pipe_MIPS32 run controller and display.
// The mode encoding lives here so the controller, display and top level decode it identically.
package mips_board_pkg;

    localparam logic [1:0] MODE_PAUSE = 2'd0;
    localparam logic [1:0] MODE_RUN   = 2'd1;
    localparam logic [1:0] MODE_STEP  = 2'd2;
    localparam logic [1:0] MODE_DONE  = 2'd3;

    // Run-controller FSM states; the encoding equals the exported mode value.
    typedef enum logic [1:0] {
        ST_PAUSE = MODE_PAUSE,
        ST_RUN   = MODE_RUN,
        ST_STEP  = MODE_STEP,
        ST_DONE  = MODE_DONE
    } run_state_e;

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton conditioner: 2-FF synchroniser, stability counter, and a one-clock
// press pulse on each accepted 0->1 transition. Releases are accepted silently.
module btn_debounce #(
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic press_pulse
);

    localparam int CW = $clog2(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pulse_q, pulse_d;

    // Two-flop synchroniser for the asynchronous button level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

    // Accept a new level only after it has differed from the stable level for DEB_CYCLES clocks.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        pulse_d  = 1'b0;
        if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            stable_d = sync2_q;
            cnt_d    = '0;
            pulse_d  = sync2_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Stability state and registered press pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_q <= 1'b0;
            cnt_q    <= '0;
            pulse_q  <= 1'b0;
        end else begin
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            pulse_q  <= pulse_d;
        end
    end

    assign press_pulse = pulse_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/step/halt sequencer for the pipe_MIPS32 core. Issues a one-clock clock-enable
// (cpu_ce) on the system clock: periodically in RUN, once per step press in PAUSE,
// never after the core reports halt. Exports the FSM state as mode and counts pulses.
//
// cpu_ce protocol: a single-cycle, registered pulse; the core advances one cycle on every
// clk edge where cpu_ce is high. There is no back-pressure, and cpu_ce is never high on
// two consecutive clocks.
module cpu_run_ctrl
    import mips_board_pkg::*;
#(
    parameter int TICK_DIV   = 50_000_000,
    parameter int DEB_CYCLES = 1_000_000,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_run,
    input  logic             btn_step,
    input  logic             cpu_halted,
    output logic             cpu_ce,
    output logic [1:0]       mode,
    output logic [CNT_W-1:0] cycle_count
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

    logic             run_p, step_p;
    run_state_e       state_q;
    logic [PW-1:0]    presc_q;
    logic             ce_q;
    logic [CNT_W-1:0] count_q;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_run (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_raw     (btn_run),
        .press_pulse (run_p)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_step (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_raw     (btn_step),
        .press_pulse (step_p)
    );

    // Sequencer FSM with prescaler; halt overrides everything and kills any due pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_PAUSE;
            presc_q <= '0;
            ce_q    <= 1'b0;
        end else if (cpu_halted) begin
            state_q <= ST_DONE;
            presc_q <= '0;
            ce_q    <= 1'b0;
        end else begin
            ce_q <= 1'b0;
            case (state_q)
                ST_PAUSE: begin
                    // Run wins over a step press arriving in the same cycle.
                    if (run_p) begin
                        state_q <= ST_RUN;
                        presc_q <= '0;
                    end else if (step_p) begin
                        state_q <= ST_STEP;
                        ce_q    <= 1'b1;
                    end
                end
                ST_STEP: begin
                    state_q <= ST_PAUSE;
                end
                ST_RUN: begin
                    // A pause press suppresses a pulse falling due in the same cycle.
                    if (run_p) begin
                        state_q <= ST_PAUSE;
                        presc_q <= '0;
                    end else if (presc_q == TICK_LAST) begin
                        presc_q <= '0;
                        ce_q    <= 1'b1;
                    end else begin
                        presc_q <= presc_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_DONE;
                end
                default: begin
                    state_q <= ST_PAUSE;
                end
            endcase
        end
    end

    // Saturating count of issued pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (ce_q && (count_q != '1)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign cpu_ce      = ce_q;
    assign mode        = state_q;
    assign cycle_count = count_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl with TICK_DIV=4, DEB_CYCLES=3, CNT_W=4.
// Expected pulses {mode, count, cycle} are queued by the stimulus; a monitor pops them on cpu_ce.
module tb_cpu_run_ctrl;
    import mips_board_pkg::*;

    localparam int TICK = 4;
    localparam int DEB  = 3;
    localparam int EW   = 22;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_run, btn_step, cpu_halted;
    logic       cpu_ce;
    logic [1:0] mode;
    logic [3:0] cycle_count;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int exp_cnt  = 0;

    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] mon_exp, mon_act;
    logic          prev_ce = 1'b0;

    cpu_run_ctrl #(.TICK_DIV(TICK), .DEB_CYCLES(DEB), .CNT_W(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_run     (btn_run),
        .btn_step    (btn_step),
        .cpu_halted  (cpu_halted),
        .cpu_ce      (cpu_ce),
        .mode        (mode),
        .cycle_count (cycle_count)
    );

    // Clock and free-running cycle index (value at a negedge = index of the last posedge).
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test by 200000 ns, expected completion");
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic wait_mode(input logic [1:0] m, input int budget, output int t);
        bit found = 1'b0;
        for (int k = 0; k < budget && !found; k++) begin
            @(negedge clk);
            if (mode == m) found = 1'b1;
        end
        t = cyc;
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL wait_mode: got mode=%0d after %0d clks, expected mode=%0d", mode, budget, m);
        end
    endtask

    task automatic push_ce(input logic [1:0] m, input int t);
        exp_q.push_back({m, 4'(exp_cnt), 16'(t)});
        if (exp_cnt < 15) exp_cnt++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        wait_neg(2);
        rst_n = 1'b1;
        wait_neg(2);
        exp_cnt = 0;
    endtask

    // Scoreboard monitor: every cpu_ce pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        #1;
        if (rst_n && cpu_ce) begin
            n_checks++;
            mon_act = {mode, cycle_count, cyc[15:0]};
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL ce_unexpected: got pulse at cyc %0d mode=%0d count=%0d, expected no pulse",
                         cyc, mode, cycle_count);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_act != mon_exp) begin
                    n_fail++;
                    $display("FAIL ce_pulse: got mode=%0d count=%0d cyc=%0d, expected mode=%0d count=%0d cyc=%0d",
                             mon_act[21:20], mon_act[19:16], mon_act[15:0],
                             mon_exp[21:20], mon_exp[19:16], mon_exp[15:0]);
                end
            end
        end
    end

    // Protocol properties: isolated pulses, and silence in DONE.
    always @(negedge clk) begin
        #1;
        if (rst_n) begin
            if (cpu_ce) begin
                n_checks++;
                if (prev_ce) begin
                    n_fail++;
                    $display("FAIL ce_back_to_back: got cpu_ce=1 at cyc %0d and %0d, expected isolated pulses", cyc - 1, cyc);
                end
            end
            if (mode == MODE_DONE) begin
                n_checks++;
                if (cpu_ce) begin
                    n_fail++;
                    $display("FAIL ce_in_done: got cpu_ce=1 at cyc %0d, expected 0", cyc);
                end
            end
        end
        prev_ce = rst_n && cpu_ce;
    end

    initial begin
        int p0, t, t2, ts, lat;
        rst_n      = 1'b0;
        btn_run    = 1'b0;
        btn_step   = 1'b0;
        cpu_halted = 1'b0;
        wait_neg(3);
        check("reset_mode", mode, MODE_PAUSE);
        check("reset_ce", cpu_ce, 0);
        check("reset_count", cycle_count, 0);
        rst_n = 1'b1;
        wait_neg(2);

        // Held run button: one press, periodic pulses every TICK clocks.
        p0 = cyc;
        btn_run = 1'b1;
        wait_mode(MODE_RUN, 20, t);
        lat = t - p0;
        n_checks++;
        if (lat < DEB + 3 || lat > DEB + 4) begin
            n_fail++;
            $display("FAIL run_press_latency: got %0d clks, expected %0d..%0d", lat, DEB + 3, DEB + 4);
            lat = DEB + 3;
        end
        push_ce(MODE_RUN, t + 4);
        push_ce(MODE_RUN, t + 8);
        push_ce(MODE_RUN, t + 12);
        push_ce(MODE_RUN, t + 16);
        wait_until(p0 + 10);
        btn_run = 1'b0;
        wait_until(t + 13);
        check("count_after_3", cycle_count, 3);
        check("held_single_press", mode, MODE_RUN);

        // Pause press landing on the edge where the 5th pulse is due.
        wait_until(t + 20 - lat);
        btn_run = 1'b1;
        wait_until(t + 20);
        check("pause_mode", mode, MODE_PAUSE);
        check("pause_ce_suppressed", cpu_ce, 0);
        btn_run = 1'b0;
        wait_neg(12);
        check("pause_count", cycle_count, 4);
        check("pause_hold", mode, MODE_PAUSE);

        // Resume: first pulse TICK clocks after entry, then halt on a due edge.
        btn_run = 1'b1;
        wait_neg(5);
        btn_run = 1'b0;
        wait_mode(MODE_RUN, 15, t2);
        push_ce(MODE_RUN, t2 + 4);
        wait_until(t2 + 7);
        cpu_halted = 1'b1;
        wait_until(t2 + 8);
        check("halt_mode", mode, MODE_DONE);
        check("halt_ce_suppressed", cpu_ce, 0);
        wait_neg(1);
        cpu_halted = 1'b0;
        btn_run = 1'b1;
        wait_neg(6);
        btn_run = 1'b0;
        wait_neg(10);
        check("done_ignores_run", mode, MODE_DONE);
        btn_step = 1'b1;
        wait_neg(6);
        btn_step = 1'b0;
        wait_neg(10);
        check("done_ignores_step", mode, MODE_DONE);
        check("done_count", cycle_count, 5);

        // Single step from PAUSE, then a short glitch.
        do_reset();
        btn_step = 1'b1;
        wait_neg(5);
        btn_step = 1'b0;
        wait_mode(MODE_STEP, 10, ts);
        push_ce(MODE_STEP, ts);
        wait_neg(1);
        check("step_back_to_pause", mode, MODE_PAUSE);
        check("step_count", cycle_count, 1);
        wait_neg(8);
        btn_step = 1'b1;
        wait_neg(2);
        btn_step = 1'b0;
        wait_neg(12);
        check("glitch_mode", mode, MODE_PAUSE);
        check("glitch_count", cycle_count, 1);

        // Twenty steps: the counter must saturate at 15.
        for (int i = 0; i < 20; i++) begin
            btn_step = 1'b1;
            wait_neg(5);
            btn_step = 1'b0;
            wait_mode(MODE_STEP, 10, ts);
            push_ce(MODE_STEP, ts);
            wait_neg(8);
        end
        check("count_saturated", cycle_count, 15);

        // Simultaneous run and step: run wins, no step pulse.
        btn_run  = 1'b1;
        btn_step = 1'b1;
        wait_neg(5);
        btn_run  = 1'b0;
        btn_step = 1'b0;
        wait_mode(MODE_RUN, 10, t);
        push_ce(MODE_RUN, t + 4);

        // Asynchronous reset while a pulse is high, between clock edges.
        wait_until(t + 4);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_ce", cpu_ce, 0);
        check("async_rst_mode", mode, MODE_PAUSE);
        check("async_rst_count", cycle_count, 0);
        wait_neg(2);
        rst_n = 1'b1;
        wait_neg(3);
        check("exp_q_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
